// File: rtl/ddr_wr_sched.sv
// Round-robin write scheduler: shares one DDR write port between four FWFT line FIFOs.
// Each grant issues one burst command, streams BURST_LEN beats, then waits for the response.
//
// state | meaning
// IDLE  | waiting for any ch_req; arbitration from ptr
// CMD   | burst command presented, waiting for wr_cmd_ready
// DATA  | streaming beats from the selected FIFO
// RESP  | waiting for wr_bvalid
module ddr_wr_sched #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 256,
    parameter int BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            ch_req,
    input  logic [4*ADDR_W-1:0]   ch_addr,
    input  logic [4*DATA_W-1:0]   ch_rd_data,
    output logic [3:0]            ch_rd_en,
    output logic [3:0]            ch_grant,
    output logic [3:0]            ch_done,
    output logic                  wr_cmd_valid,
    input  logic                  wr_cmd_ready,
    output logic [ADDR_W-1:0]     wr_cmd_addr,
    output logic [7:0]            wr_cmd_len,
    output logic                  wr_data_valid,
    input  logic                  wr_data_ready,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  wr_data_last,
    input  logic                  wr_bvalid,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, RESP} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          sel_q, sel_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [3:0]          grant_q, grant_d;
    logic [3:0]          done_q, done_d;

    logic [ADDR_W-1:0]   addr_arr [4];
    logic [DATA_W-1:0]   data_arr [4];
    logic [1:0]          winner;
    logic [1:0]          idx;
    logic                found;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            addr_arr[k] = ch_addr[k*ADDR_W +: ADDR_W];
            data_arr[k] = ch_rd_data[k*DATA_W +: DATA_W];
        end
    end

    // First requester at or above ptr, wrapping 3 -> 0.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && ch_req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        cmd_addr_d = cmd_addr_q;
        grant_d    = 4'b0000;
        done_d     = 4'b0000;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = CMD;
                    sel_d      = winner;
                    cmd_addr_d = addr_arr[winner];
                    grant_d    = 4'b0001 << winner;
                    ptr_d      = winner + 2'd1;
                end
            end
            CMD: begin
                if (wr_cmd_ready) begin
                    state_d    = DATA;
                    beat_cnt_d = '0;
                end
            end
            DATA: begin
                if (wr_data_ready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (wr_bvalid) begin
                    state_d = IDLE;
                    done_d  = 4'b0001 << sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            cmd_addr_q <= '0;
            grant_q    <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
            cmd_addr_q <= cmd_addr_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
        end
    end

    assign wr_cmd_valid  = (state_q == CMD);
    assign wr_cmd_addr   = cmd_addr_q;
    assign wr_cmd_len    = LAST_BEAT;
    assign wr_data_valid = (state_q == DATA);
    assign wr_data_last  = (state_q == DATA) && (beat_cnt_q == LAST_BEAT);
    // Data is forced to zero outside DATA so an abandoned burst leaves nothing on the bus.
    assign wr_data       = (state_q == DATA) ? data_arr[sel_q] : '0;
    assign ch_rd_en      = ((state_q == DATA) && wr_data_ready) ? (4'b0001 << sel_q) : 4'b0000;
    assign ch_grant      = grant_q;
    assign ch_done       = done_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_wr_sched.sv
// Directed bench for ddr_wr_sched: single burst, round robin, backpressure,
// pointer wrap, stray responses and reset mid-burst.
module tb_ddr_wr_sched;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 256;
    localparam int BL     = 16;

    logic                clk;
    logic                rst;
    logic [3:0]          ch_req;
    logic [4*ADDR_W-1:0] ch_addr;
    logic [4*DATA_W-1:0] ch_rd_data;
    logic [3:0]          ch_rd_en;
    logic [3:0]          ch_grant;
    logic [3:0]          ch_done;
    logic                wr_cmd_valid;
    logic                wr_cmd_ready;
    logic [ADDR_W-1:0]   wr_cmd_addr;
    logic [7:0]          wr_cmd_len;
    logic                wr_data_valid;
    logic                wr_data_ready;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_data_last;
    logic                wr_bvalid;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;
    int pops;
    int acc;

    ddr_wr_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_addr(ch_addr), .ch_rd_data(ch_rd_data),
        .ch_rd_en(ch_rd_en), .ch_grant(ch_grant), .ch_done(ch_done),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_len(wr_cmd_len), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .wr_data(wr_data), .wr_data_last(wr_data_last), .wr_bvalid(wr_bvalid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [ADDR_W-1:0] addr_of(input int k);
        return 28'hA00_0000 + 28'(k) * 28'h010_0040;
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input int k);
        return {8{32'hDA7A_0000 + 32'(k)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one cycle before the granting edge, ends in the IDLE cycle after the response.
    task automatic burst(input int ch);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        tick();
        chk("grant", ch_grant, oh);
        chk("cmd_valid", wr_cmd_valid, 1'b1);
        chk("cmd_addr", wr_cmd_addr, addr_of(ch));
        chk("busy_cmd", busy, 1'b1);
        tick();
        chk("grant_pulse", ch_grant, 4'b0000);
        for (int b = 0; b < BL; b++) begin
            chk("data_valid", wr_data_valid, 1'b1);
            chk("rd_en", ch_rd_en, oh);
            chk("wr_data", wr_data, data_of(ch));
            chk("last", wr_data_last, (b == BL - 1));
            tick();
        end
        chk("resp_valid", wr_data_valid, 1'b0);
        chk("resp_busy", busy, 1'b1);
        chk("resp_done", ch_done, 4'b0000);
        wr_bvalid = 1'b1;
        tick();
        wr_bvalid = 1'b0;
        chk("done", ch_done, oh);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ch_req = '0;
        wr_cmd_ready = 1'b1;
        wr_data_ready = 1'b1;
        wr_bvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ch_addr[k*ADDR_W +: ADDR_W]    = addr_of(k);
            ch_rd_data[k*DATA_W +: DATA_W] = data_of(k);
        end
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_valid", wr_cmd_valid, 1'b0);
        chk("rst_data_valid", wr_data_valid, 1'b0);
        chk("rst_last", wr_data_last, 1'b0);
        chk("rst_grant", ch_grant, 4'b0000);
        chk("rst_rd_en", ch_rd_en, 4'b0000);
        chk("rst_done", ch_done, 4'b0000);
        chk("rst_addr", wr_cmd_addr, '0);
        chk("cmd_len", wr_cmd_len, 8'd15);
        rst = 1'b0;

        // Single request on channel 0.
        ch_req = 4'b0001;
        burst(0);
        ch_req = 4'b0000;
        tick();
        chk("single_after_busy", busy, 1'b0);
        chk("single_after_done", ch_done, 4'b0000);

        // Round robin from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ch_req = 4'b1111;
        for (int i = 0; i < 8; i++) burst(i % 4);

        // Last grant was channel 3: pointer must wrap to 0.
        ch_req = 4'b1001;
        burst(0);
        ch_req = 4'b0000;

        // Backpressure on channel 2: command stall, then alternating data ready.
        ch_req = 4'b0100;
        wr_cmd_ready = 1'b0;
        tick();
        chk("bp_grant", ch_grant, 4'b0100);
        ch_req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_valid", wr_cmd_valid, 1'b1);
            chk("bp_cmd_addr", wr_cmd_addr, addr_of(2));
            chk("bp_no_data", wr_data_valid, 1'b0);
            tick();
        end
        chk("bp_cmd_hold", wr_cmd_valid, 1'b1);
        wr_cmd_ready = 1'b1;
        tick();
        pops = 0;
        acc = 0;
        for (int c = 0; c < 80 && acc < BL; c++) begin
            wr_data_ready = c[0];
            #1;
            chk("bp_valid", wr_data_valid, 1'b1);
            chk("bp_last", wr_data_last, (acc == BL - 1));
            chk("bp_rd_en", ch_rd_en, wr_data_ready ? 4'b0100 : 4'b0000);
            if (ch_rd_en[2]) pops++;
            if (wr_data_valid && wr_data_ready) acc++;
            tick();
        end
        wr_data_ready = 1'b1;
        chk("bp_pops", pops, 16);
        chk("bp_accepted", acc, 16);
        chk("bp_resp", wr_data_valid, 1'b0);
        wr_bvalid = 1'b1;
        tick();
        wr_bvalid = 1'b0;
        chk("bp_done", ch_done, 4'b0100);

        // Stray response while idle.
        wr_bvalid = 1'b1;
        tick();
        wr_bvalid = 1'b0;
        chk("stray_idle_done", ch_done, 4'b0000);
        chk("stray_idle_busy", busy, 1'b0);

        // Channel 1 burst: stray response during DATA, then reset after five beats.
        ch_req = 4'b0010;
        tick();
        chk("rd_grant", ch_grant, 4'b0010);
        ch_req = 4'b0000;
        tick();
        for (int b = 0; b < 5; b++) begin
            chk("rd_rd_en", ch_rd_en, 4'b0010);
            if (b == 2) wr_bvalid = 1'b1;
            tick();
            wr_bvalid = 1'b0;
            chk("stray_data_done", ch_done, 4'b0000);
        end
        chk("rd_still_data", wr_data_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_cmd_valid", wr_cmd_valid, 1'b0);
        chk("mrst_data_valid", wr_data_valid, 1'b0);
        chk("mrst_last", wr_data_last, 1'b0);
        chk("mrst_grant", ch_grant, 4'b0000);
        chk("mrst_rd_en", ch_rd_en, 4'b0000);
        chk("mrst_done", ch_done, 4'b0000);
        chk("mrst_addr", wr_cmd_addr, '0);
        rst = 1'b0;
        // Channels 1 and 3 request: a cleared pointer must pick 1.
        ch_req = 4'b1010;
        burst(1);
        ch_req = 4'b0000;
        tick();
        chk("final_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr_wr_sched.md
# ddr_wr_sched

Round-robin write scheduler that shares one DDR write port between four video ingest channels. Channel 0 is the HDMI-in RGB565 path; channels 1-3 are additional capture sources. Each channel owns a first-word-fall-through line FIFO and raises a request once it holds a full burst. The scheduler picks one channel, issues a burst write command, streams the burst out of that channel's FIFO, waits for the write response, then re-arbitrates.

## Interface
Parameters:
- ADDR_W, 28, DDR byte-address width
- DATA_W, 256, DDR data width; each channel FIFO is also DATA_W wide
- BURST_LEN, 16, beats per burst; legal range 2..256

Ports:
- clk  in  1  single clock; every port is synchronous to it
- rst  in  1  synchronous, active-high reset
- ch_req  in  4  bit k high means channel k holds at least BURST_LEN beats
- ch_addr  in  4*ADDR_W  burst start address; channel k occupies bits [k*ADDR_W +: ADDR_W]
- ch_rd_data  in  4*DATA_W  FWFT FIFO head word; channel k occupies bits [k*DATA_W +: DATA_W]
- ch_rd_en  out  4  FIFO pop strobe, one-hot or zero
- ch_grant  out  4  one-cycle one-hot pulse when a channel is selected
- ch_done  out  4  one-cycle one-hot pulse when that channel's burst response arrives
- wr_cmd_valid  out  1  write command valid
- wr_cmd_ready  in  1  write command accepted
- wr_cmd_addr  out  ADDR_W  latched address of the granted channel
- wr_cmd_len  out  8  constant BURST_LEN-1
- wr_data_valid  out  1  write data beat valid
- wr_data_ready  in  1  write data beat accepted
- wr_data  out  DATA_W  ch_rd_data of the granted channel, muxed combinationally
- wr_data_last  out  1  marks the final beat of the burst
- wr_bvalid  in  1  write response pulse
- busy  out  1  high whenever the state is not IDLE

## Operation
- State machine: IDLE, CMD, DATA, RESP.
- IDLE to CMD:
  - Taken when ch_req is nonzero.
  - The winner is the first set bit searching from the priority pointer ptr upward, wrapping 3 to 0.
  - On this transition: register sel, latch wr_cmd_addr from ch_addr[sel], pulse ch_grant[sel], set ptr to (sel+1) mod 4.
- CMD:
  - wr_cmd_valid is high.
  - When wr_cmd_valid and wr_cmd_ready are both high, clear wr_cmd_valid, clear beat_cnt, go to DATA.
  - wr_cmd_addr stays stable while wr_cmd_valid is high.
- DATA:
  - wr_data_valid is high and wr_data = ch_rd_data[sel].
  - ch_rd_en[sel] = wr_data_valid & wr_data_ready; all other ch_rd_en bits are 0.
  - beat_cnt increments on each accepted beat.
  - wr_data_last is high while beat_cnt == BURST_LEN-1.
  - The accepted last beat moves the state to RESP.
- RESP:
  - wr_bvalid moves the state to IDLE and pulses ch_done[sel] on the same edge.
  - wr_bvalid outside RESP is ignored.
- ch_req is sampled only in IDLE. A request that drops after its grant does not abort the burst; the channel guarantees its data.
- ptr updates only on a grant, so a channel is never granted twice in a row while another channel is requesting.
- wr_data_valid and wr_cmd_valid are never high together. Their handshakes are never in the same cycle.

## Timing
- Reset, synchronous: state=IDLE, ptr=0, sel=0, beat_cnt=0.
- Outputs in reset: wr_cmd_valid, wr_data_valid, wr_data_last, busy, ch_grant, ch_rd_en, ch_done and wr_cmd_addr are all 0.
- rst asserted mid-burst takes effect at the next edge: all outputs go to 0 and the burst is abandoned without completing.
- Grant latency: ch_req is seen in IDLE at edge n; ch_grant and wr_cmd_valid are high in cycle n+1.
- With wr_cmd_ready constantly high, the first data beat is valid in cycle n+2.
- With ready constantly high, the last data beat is in cycle n+1+BURST_LEN.
- RESP is entered the cycle after the last beat and lasts at least one cycle.
- The earliest next grant is one cycle after the wr_bvalid edge: bvalid at edge m means IDLE in cycle m+1 and the next grant in cycle m+2.
- Backpressure:
  - wr_data_ready low holds wr_data_valid high, holds beat_cnt and wr_data_last, and holds ch_rd_en at 0.
  - wr_cmd_ready low holds wr_cmd_valid high indefinitely.

## Test plan
- Single request: ch_req=4'b0001, ready=1, BURST_LEN=16.
  - Required: ch_grant=0001, then 16 beats with ch_rd_en[0] high on each.
  - wr_data_last on beat 16 only; ch_done[0] on bvalid; busy low afterwards.
- All request: ch_req held at 4'b1111 for 8 bursts.
  - Required grant order is 0,1,2,3,0,1,2,3.
  - wr_cmd_addr matches ch_addr of each granted channel.
- Backpressure: toggle wr_data_ready every cycle; hold wr_cmd_ready low for 5 cycles.
  - Required: exactly 16 pops and 16 accepted beats; wr_cmd_addr stable while wr_cmd_valid is high.
- Pointer wrap: grant channel 3; then ch_req=4'b1001.
  - Required: next grant is channel 0, not 3.
- Reset mid-DATA: assert rst after beat 5.
  - Required: all outputs 0 at the next edge; ptr=0.
  - After release, ch_req=4'b0010 is granted channel 1 normally.
- Stray response: pulse wr_bvalid during IDLE and during DATA.
  - Required: no ch_done pulse and no state change.
